cpu_bus_fabric_rv32: RTL and testbench

Parametrised CPU-side bus fabric for the RV32 subsystem. Replaces the fixed address-register/read-mux/reset-counter logic with a generic N-region decoder, registered read-data mux, per-region wait-state generator driving the CPU halt, a configurable power-on reset sequencer and unmapped-access error capture. Sits between `cpu_rv32`/`cpu_rv32_serv` and the internal plus interface-side peripherals.

---
 rtl/cpu_bus_fabric_rv32.sv | 184 ++++++++++++++++++
 tb/tb_cpu_bus_fabric_rv32.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_fabric_rv32.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_fabric_rv32
// Brief    : RV32 CPU-side bus fabric: N-region decoder, registered read-data
//            mux, per-region wait states, power-on reset sequencer. Defining
//            BUS_ERROR_CAPTURE_EN adds unmapped-access error capture.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_fabric_rv32 #(
    parameter int NumRegions      = 8,
    parameter int address_width   = 32,
    parameter int data_width      = 32,
    parameter logic [NumRegions*address_width-1:0] RegionBase = '0,
    parameter logic [NumRegions*address_width-1:0] RegionEnd  = '0,
    parameter logic [NumRegions*4-1:0]             RegionWait = '0,
    parameter int ResetHoldCycles = 6
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [address_width-1:0]         cpu_address_i,
    input  logic                             cpu_req_i,
    input  logic                             cpu_we_i,
    input  logic                             ext_halt_i,
    input  logic [NumRegions*data_width-1:0] slave_data_i,
    input  logic                             err_clear_i,
    output logic [data_width-1:0]            cpu_data_o,
    output logic                             cpu_halt_o,
    output logic [NumRegions-1:0]            slave_sel_o,
    output logic                             cpu_reset_o,
    output logic                             bus_error_o,
    output logic                             err_valid_o,
    output logic [address_width-1:0]         err_address_o
);

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_WAIT = 1'b1;
    localparam logic [7:0] C_HOLD    = 8'(ResetHoldCycles);

    // Offset compare is equivalent to base <= a <= end for well-formed regions
    // and avoids constant-folded compares against a zero base.
    function automatic logic [NumRegions-1:0] f_decode(input logic [address_width-1:0] a);
        logic [NumRegions-1:0] sel;
        logic                  found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NumRegions; i++) begin
            if (!found &&
                ((a - RegionBase[i*address_width +: address_width]) <=
                 (RegionEnd[i*address_width +: address_width] -
                  RegionBase[i*address_width +: address_width]))) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return sel;
    endfunction

    logic [NumRegions-1:0]    w_sel;
    logic [NumRegions-1:0]    w_qsel;
    logic                     w_hit;
    logic [3:0]               w_wait;
    logic [address_width-1:0] r_addr_q;
    logic [0:0]               r_state;
    logic [3:0]               r_wcnt;
    logic                     w_req_idle;
    logic                     w_start;
    logic [7:0]               r_rst_cnt;

    assign w_sel       = f_decode(cpu_address_i);
    assign w_qsel      = f_decode(r_addr_q);
    assign w_hit       = |w_sel;
    assign slave_sel_o = w_sel;

    always_comb begin
        w_wait = '0;
        for (int i = 0; i < NumRegions; i++) begin
            if (w_sel[i]) begin
                w_wait = RegionWait[i*4 +: 4];
            end
        end
    end

    always_comb begin
        cpu_data_o = '0;
        for (int i = 0; i < NumRegions; i++) begin
            if (w_qsel[i]) begin
                cpu_data_o = slave_data_i[i*data_width +: data_width];
            end
        end
    end

    // Requests are only accepted in IDLE; the request cycle itself is the
    // first halt cycle, so WAIT covers the remaining w-1 cycles.
    assign w_req_idle = cpu_req_i && (r_state == C_ST_IDLE);
    assign w_start    = w_req_idle && (w_wait != 4'd0);
    assign cpu_halt_o = ext_halt_i || (r_state == C_ST_WAIT) || w_start;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= C_ST_IDLE;
            r_wcnt  <= 4'd0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_start && (w_wait > 4'd1)) begin
                        r_state <= C_ST_WAIT;
                        r_wcnt  <= w_wait - 4'd1;
                    end
                end
                C_ST_WAIT: begin
                    if (r_wcnt <= 4'd1) begin
                        r_state <= C_ST_IDLE;
                        r_wcnt  <= 4'd0;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                    r_wcnt  <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_addr_q <= '0;
        end else if (!cpu_halt_o) begin
            r_addr_q <= cpu_address_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rst_cnt <= 8'd0;
        end else if (r_rst_cnt != 8'hFF) begin
            r_rst_cnt <= r_rst_cnt + 8'd1;
        end
    end

    assign cpu_reset_o = reset_i || (r_rst_cnt < C_HOLD);

`ifdef BUS_ERROR_CAPTURE_EN
    logic                     w_err;
    logic                     r_bus_error;
    logic                     r_err_valid;
    logic [address_width-1:0] r_err_address;
    logic                     w_unused;

    assign w_err = w_req_idle && !w_hit;

    // A new error in the same cycle as a clear is captured and keeps the flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_bus_error   <= 1'b0;
            r_err_valid   <= 1'b0;
            r_err_address <= '0;
        end else begin
            r_bus_error <= w_err;
            if (w_err && (!r_err_valid || err_clear_i)) begin
                r_err_valid   <= 1'b1;
                r_err_address <= cpu_address_i;
            end else if (err_clear_i) begin
                r_err_valid <= 1'b0;
            end
        end
    end

    assign bus_error_o   = r_bus_error;
    assign err_valid_o   = r_err_valid;
    assign err_address_o = r_err_address;
    assign w_unused      = cpu_we_i;
`else
    logic w_unused;

    assign bus_error_o   = 1'b0;
    assign err_valid_o   = 1'b0;
    assign err_address_o = '0;
    assign w_unused      = ^{cpu_we_i, err_clear_i, w_hit};
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_fabric_rv32.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_bus_fabric_rv32
// Brief    : Directed bench for cpu_bus_fabric_rv32 with a region-table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_fabric_rv32;

    localparam int NR   = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int HOLD = 6;
`ifdef BUS_ERROR_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            r_reset = 1'b1;
    logic [AW-1:0]   r_addr = '0;
    logic            r_req = 1'b0;
    logic            r_we = 1'b0;
    logic            r_ext = 1'b0;
    logic            r_clear = 1'b0;
    logic [NR*DW-1:0] r_sdata = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    logic [DW-1:0]   w_data;
    logic            w_halt;
    logic [NR-1:0]   w_sel;
    logic            w_cpu_reset;
    logic            w_bus_error;
    logic            w_err_valid;
    logic [AW-1:0]   w_err_address;

    always #5 clk = ~clk;

    cpu_bus_fabric_rv32 #(
        .NumRegions     (NR),
        .address_width  (AW),
        .data_width     (DW),
        .RegionBase     ({32'h0000_9020, 32'h0000_9010, 32'h0000_9000, 32'h0000_0000}),
        .RegionEnd      ({32'h0000_902F, 32'h0000_901F, 32'h0000_900F, 32'h0000_7FFF}),
        .RegionWait     ({4'd0, 4'd3, 4'd0, 4'd0}),
        .ResetHoldCycles(HOLD)
    ) dut (
        .clk_i        (clk),
        .reset_i      (r_reset),
        .cpu_address_i(r_addr),
        .cpu_req_i    (r_req),
        .cpu_we_i     (r_we),
        .ext_halt_i   (r_ext),
        .slave_data_i (r_sdata),
        .err_clear_i  (r_clear),
        .cpu_data_o   (w_data),
        .cpu_halt_o   (w_halt),
        .slave_sel_o  (w_sel),
        .cpu_reset_o  (w_cpu_reset),
        .bus_error_o  (w_bus_error),
        .err_valid_o  (w_err_valid),
        .err_address_o(w_err_address)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Region table as the system map describes it.
    logic [31:0] m_base [NR] = '{32'h0000_0000, 32'h0000_9000, 32'h0000_9010, 32'h0000_9020};
    logic [31:0] m_end  [NR] = '{32'h0000_7FFF, 32'h0000_900F, 32'h0000_901F, 32'h0000_902F};
    int          m_wait [NR] = '{0, 0, 3, 0};

    function automatic int region_of(input logic [31:0] a);
        for (int i = 0; i < NR; i++) begin
            if (a >= m_base[i] && a <= m_end[i]) return i;
        end
        return -1;
    endfunction

    bit          model_en = 1'b0;
    int          m_low = 0;
    logic [31:0] m_addr = '0;
    int          m_stall = 0;
    bit          m_pulse = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_eaddr = '0;
    int          c_idx, q_idx, c_w;
    bit          e_start, e_halt, e_err;

    always @(negedge clk) begin
        if (model_en) begin
            c_idx   = region_of(r_addr);
            q_idx   = region_of(m_addr);
            c_w     = (c_idx >= 0) ? m_wait[c_idx] : 0;
            e_start = r_req && (m_stall == 0) && (c_w > 0);
            e_halt  = r_ext || (m_stall > 0) || e_start;
            e_err   = r_req && (m_stall == 0) && (c_idx < 0);

            check("sel",       64'(w_sel), (c_idx >= 0) ? (64'd1 << c_idx) : 64'd0);
            check("data",      64'(w_data), (q_idx >= 0) ? 64'(32'hA0 + q_idx) : 64'd0);
            check("halt",      64'(w_halt), 64'(e_halt));
            check("cpu_reset", 64'(w_cpu_reset), 64'(r_reset || (m_low < HOLD)));
            check("bus_error", 64'(w_bus_error), 64'(m_pulse && CAP));
            check("err_valid", 64'(w_err_valid), 64'(m_valid && CAP));
            check("err_addr",  64'(w_err_address), CAP ? 64'(m_eaddr) : 64'd0);

            if (r_reset) begin
                m_low   = 0;
                m_addr  = '0;
                m_stall = 0;
                m_pulse = 1'b0;
                m_valid = 1'b0;
                m_eaddr = '0;
            end else begin
                if (m_low < 1000) m_low++;
                if (!e_halt) m_addr = r_addr;
                if (m_stall > 0) m_stall--;
                else if (e_start) m_stall = c_w - 1;
                m_pulse = e_err;
                if (e_err && (!m_valid || r_clear)) begin
                    m_valid = 1'b1;
                    m_eaddr = r_addr;
                end else if (r_clear) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        model_en = 1'b1;
        step();
        @(negedge clk);
        check("rst_data",      64'(w_data), 64'hA0);
        check("rst_halt",      64'(w_halt), 64'd0);
        check("rst_cpu_reset", 64'(w_cpu_reset), 64'd1);
        check("rst_err_valid", 64'(w_err_valid), 64'd0);
        check("rst_bus_error", 64'(w_bus_error), 64'd0);
        step();
        r_reset = 1'b0;

        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("hold1", 64'(w_cpu_reset), (k < 6) ? 64'd1 : 64'd0);
            step();
        end
        repeat (13) step();
        r_reset = 1'b1;
        @(negedge clk);
        check("repulse", 64'(w_cpu_reset), 64'd1);
        step();
        r_reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("hold2", 64'(w_cpu_reset), (k < 6) ? 64'd1 : 64'd0);
            step();
        end

        // zero-wait read of R1
        r_addr = 32'h9004;
        r_req  = 1'b1;
        @(negedge clk);
        check("zw_sel",  64'(w_sel), 64'h2);
        check("zw_halt", 64'(w_halt), 64'd0);
        step();
        r_req = 1'b0;
        @(negedge clk);
        check("zw_data", 64'(w_data), 64'hA1);
        step();

        // three wait states on R2, address presented a cycle ahead
        r_addr = 32'h9014;
        step();
        r_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ws_halt", 64'(w_halt), (k < 3) ? 64'd1 : 64'd0);
            check("ws_data", 64'(w_data), 64'hA2);
            step();
            r_req = 1'b0;
        end

        r_req = 1'b1;
        r_we  = 1'b1;
        step();
        r_req = 1'b0;
        r_we  = 1'b0;
        repeat (4) step();

        // external halt outlasting the wait states
        r_req = 1'b1;
        r_ext = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("ext_halt", 64'(w_halt), (k < 5) ? 64'd1 : 64'd0);
            step();
            r_req = 1'b0;
            if (k >= 4) r_ext = 1'b0;
        end

        r_addr = 32'h9024;
        r_req  = 1'b1;
        step();
        r_req = 1'b0;
        @(negedge clk);
        check("r3_data", 64'(w_data), 64'hA3);
        step();

        // unmapped accesses and error capture
        r_addr = 32'hF000;
        r_req  = 1'b1;
        @(negedge clk);
        check("um_sel",  64'(w_sel), 64'd0);
        check("um_halt", 64'(w_halt), 64'd0);
        step();
        r_req = 1'b0;
        @(negedge clk);
        check("um_data",  64'(w_data), 64'd0);
        check("um_pulse", 64'(w_bus_error), 64'(CAP));
        check("um_valid", 64'(w_err_valid), 64'(CAP));
        check("um_addr",  64'(w_err_address), CAP ? 64'hF000 : 64'd0);
        step();
        @(negedge clk);
        check("um_pulse_end", 64'(w_bus_error), 64'd0);
        r_addr = 32'hF004;
        r_req  = 1'b1;
        step();
        r_req = 1'b0;
        @(negedge clk);
        check("um2_pulse", 64'(w_bus_error), 64'(CAP));
        check("um2_addr",  64'(w_err_address), CAP ? 64'hF000 : 64'd0);
        step();
        r_addr  = 32'hF008;
        r_req   = 1'b1;
        r_clear = 1'b1;
        step();
        r_req   = 1'b0;
        r_clear = 1'b0;
        @(negedge clk);
        check("um3_valid", 64'(w_err_valid), 64'(CAP));
        check("um3_addr",  64'(w_err_address), CAP ? 64'hF008 : 64'd0);
        step();
        r_clear = 1'b1;
        step();
        r_clear = 1'b0;
        @(negedge clk);
        check("clr_valid", 64'(w_err_valid), 64'd0);
        step();

        // reset during the second halt cycle of an R2 access
        r_addr = 32'h9014;
        step();
        r_req = 1'b1;
        step();
        r_req   = 1'b0;
        r_reset = 1'b1;
        @(negedge clk);
        check("mw_halt_in", 64'(w_halt), 64'd1);
        step();
        r_reset = 1'b0;
        @(negedge clk);
        check("mw_halt_out", 64'(w_halt), 64'd0);
        check("mw_cpu_reset", 64'(w_cpu_reset), 64'd1);
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
